// File: rtl/pkt_decode_ctrl.sv
// Packet decoder control: tracks token/data PIDs, steers DATA payload bytes into a block buffer
// and raises the handshake pulses (ack, nack, host_ready, etc.).
module pkt_decode_ctrl #(
    parameter logic [6:0]  DEV_ADDR      = 7'h61,
    parameter int unsigned PAYLOAD_BYTES = 40,
    parameter int unsigned NUM_PACKETS   = 2,
    localparam int unsigned SEL_W = (NUM_PACKETS * PAYLOAD_BYTES > 1) ?
                                    $clog2(NUM_PACKETS * PAYLOAD_BYTES) : 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             write_enable,
    input  logic [7:0]       rx_data,
    input  logic             eop,
    input  logic             rcv_error,
    output logic             i_data_en,
    output logic [SEL_W-1:0] i_data_sel,
    output logic [7:0]       i_data,
    output logic             p_error,
    output logic             host_ready,
    output logic             quit_hash,
    output logic             new_block,
    output logic             transmit_ack,
    output logic             transmit_nack
);

    localparam int unsigned IDX_W = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;

    localparam logic [7:0] PidIn    = 8'h69;
    localparam logic [7:0] PidOut   = 8'hE1;
    localparam logic [7:0] PidData0 = 8'hC3;
    localparam logic [7:0] PidData1 = 8'h4B;

    typedef enum logic [3:0] {
        StIdle, StInAddr, StInEop, StOutAddr, StData, StDataEop, StEopEnd,
        StDrain, StDupDrain, StDupEnd, StErr, StErrDrain, StErrEnd
    } state_e;

    state_e           state_q, state_d;
    logic             armed_q, armed_d;
    logic             exp_tog_q, exp_tog_d;
    logic [IDX_W-1:0] pkt_idx_q, pkt_idx_d;
    logic [7:0]       byte_cnt_q, byte_cnt_d;
    // Remembers that the bus eop was already seen when the error was taken.
    logic             err_eop_q, err_eop_d;

    logic addr_match;
    logic pid_ok;
    logic last_byte;
    logic last_pkt;
    logic err_exempt;

    assign addr_match = (rx_data[7:1] == DEV_ADDR);
    assign pid_ok     = (rx_data[3:0] == ~rx_data[7:4]);
    assign last_byte  = (byte_cnt_q == 8'(PAYLOAD_BYTES - 1));
    assign last_pkt   = (pkt_idx_q == IDX_W'(NUM_PACKETS - 1));
    assign err_exempt = state_q inside {StIdle, StErr, StErrDrain, StErrEnd};

    assign i_data     = rx_data;
    assign i_data_sel = SEL_W'(pkt_idx_q) * SEL_W'(PAYLOAD_BYTES) + SEL_W'(byte_cnt_q);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            armed_q    <= 1'b0;
            exp_tog_q  <= 1'b0;
            pkt_idx_q  <= '0;
            byte_cnt_q <= '0;
            err_eop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            exp_tog_q  <= exp_tog_d;
            pkt_idx_q  <= pkt_idx_d;
            byte_cnt_q <= byte_cnt_d;
            err_eop_q  <= err_eop_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        armed_d       = armed_q;
        exp_tog_d     = exp_tog_q;
        pkt_idx_d     = pkt_idx_q;
        byte_cnt_d    = byte_cnt_q;
        err_eop_d     = err_eop_q;
        i_data_en     = 1'b0;
        p_error       = 1'b0;
        host_ready    = 1'b0;
        quit_hash     = 1'b0;
        new_block     = 1'b0;
        transmit_ack  = 1'b0;
        transmit_nack = 1'b0;

        if (rcv_error && !err_exempt) begin
            state_d   = StErr;
            err_eop_d = eop;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (write_enable) begin
                        if (!pid_ok) begin
                            state_d   = StErr;
                            err_eop_d = eop;
                        end else if (rx_data == PidIn) begin
                            state_d = StInAddr;
                        end else if (rx_data == PidOut) begin
                            state_d = StOutAddr;
                        end else if (rx_data == PidData0 || rx_data == PidData1) begin
                            if (!armed_q) begin
                                state_d = StDrain;
                            end else if ((rx_data == PidData1) != exp_tog_q) begin
                                state_d = StDupDrain;
                            end else begin
                                state_d = StData;
                            end
                        end else begin
                            state_d = StDrain;
                        end
                    end
                end
                StInAddr: begin
                    if (eop) begin
                        state_d = StIdle;
                    end else if (write_enable) begin
                        state_d = addr_match ? StInEop : StDrain;
                    end
                end
                StInEop: begin
                    if (eop) begin
                        host_ready = 1'b1;
                        state_d    = StIdle;
                    end
                end
                StOutAddr: begin
                    if (eop) begin
                        state_d = StIdle;
                    end else if (write_enable) begin
                        armed_d = addr_match;
                        state_d = StDrain;
                    end
                end
                StData: begin
                    if (eop) begin
                        state_d   = StErr;
                        err_eop_d = 1'b1;
                    end else if (write_enable) begin
                        i_data_en = 1'b1;
                        quit_hash = (pkt_idx_q == '0) && (byte_cnt_q == '0);
                        if (last_byte) begin
                            byte_cnt_d = '0;
                            state_d    = StDataEop;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 8'd1;
                        end
                    end
                end
                StDataEop: begin
                    if (eop) begin
                        exp_tog_d = ~exp_tog_q;
                        if (last_pkt) begin
                            pkt_idx_d = '0;
                            new_block = 1'b1;
                        end else begin
                            pkt_idx_d = pkt_idx_q + IDX_W'(1);
                        end
                        state_d = StEopEnd;
                    end else if (write_enable) begin
                        state_d   = StErr;
                        err_eop_d = 1'b0;
                    end
                end
                StEopEnd: begin
                    if (!eop) begin
                        transmit_ack = 1'b1;
                        state_d      = StIdle;
                    end
                end
                StDrain: begin
                    if (eop) state_d = StIdle;
                end
                StDupDrain: begin
                    if (eop) state_d = StDupEnd;
                end
                StDupEnd: begin
                    if (!eop) begin
                        transmit_ack = 1'b1;
                        state_d      = StIdle;
                    end
                end
                StErr: begin
                    p_error    = 1'b1;
                    byte_cnt_d = '0;
                    pkt_idx_d  = '0;
                    err_eop_d  = 1'b0;
                    state_d    = (eop || err_eop_q) ? StErrEnd : StErrDrain;
                end
                StErrDrain: begin
                    if (eop) state_d = StErrEnd;
                end
                StErrEnd: begin
                    if (!eop) begin
                        transmit_nack = 1'b1;
                        state_d       = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_decode_ctrl.sv
// Randomized scoreboard bench for pkt_decode_ctrl: a packet-level model predicts pulse events,
// a negedge monitor pops and compares them as the DUT raises its outputs.
module tb_pkt_decode_ctrl;

    localparam logic [6:0]  DEV   = 7'h61;
    localparam int unsigned PB    = 40;
    localparam int unsigned NP    = 2;
    localparam int unsigned SEL_W = 7;

    typedef struct packed {
        logic perr, hrdy, qh, nb, ack, nack, en;
        logic [SEL_W-1:0] sel;
    } ev_t;

    localparam int KPerr = 0, KHrdy = 1, KNb = 2, KAck = 3, KNack = 4, KEn = 5, KEnQh = 6;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             write_enable;
    logic [7:0]       rx_data;
    logic             eop;
    logic             rcv_error;
    logic             i_data_en;
    logic [SEL_W-1:0] i_data_sel;
    logic [7:0]       i_data;
    logic             p_error, host_ready, quit_hash, new_block, transmit_ack, transmit_nack;

    int total = 0;
    int bad   = 0;

    ev_t        exp_q[$];
    logic [7:0] frame[$];

    bit m_armed = 0;
    bit m_tog   = 0;
    int m_idx   = 0;

    pkt_decode_ctrl #(
        .DEV_ADDR     (DEV),
        .PAYLOAD_BYTES(PB),
        .NUM_PACKETS  (NP)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .write_enable (write_enable),
        .rx_data      (rx_data),
        .eop          (eop),
        .rcv_error    (rcv_error),
        .i_data_en    (i_data_en),
        .i_data_sel   (i_data_sel),
        .i_data       (i_data),
        .p_error      (p_error),
        .host_ready   (host_ready),
        .quit_hash    (quit_hash),
        .new_block    (new_block),
        .transmit_ack (transmit_ack),
        .transmit_nack(transmit_nack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, act, req);
        end
    endtask

    function automatic void push(input int kind, input int sel);
        ev_t e;
        e = '0;
        case (kind)
            KPerr: e.perr = 1'b1;
            KHrdy: e.hrdy = 1'b1;
            KNb:   e.nb   = 1'b1;
            KAck:  e.ack  = 1'b1;
            KNack: e.nack = 1'b1;
            KEn:   begin e.en = 1'b1; e.sel = SEL_W'(sel); end
            default: begin e.en = 1'b1; e.qh = 1'b1; e.sel = SEL_W'(sel); end
        endcase
        exp_q.push_back(e);
    endfunction

    // Packet-level reference: predicts the pulse sequence of one frame from the protocol rules.
    function automatic void model_frame(input int err_at, input int rst_at);
        logic [7:0] pid;
        int nb;
        int cut;
        bit acc;
        pid = frame[0];
        nb  = frame.size() - 1;
        if (pid[3:0] != ~pid[7:4]) begin
            push(KPerr, 0); push(KNack, 0); m_idx = 0;
            return;
        end
        if (pid == 8'h69) begin
            if (nb > 0 && frame[1][7:1] == DEV) push(KHrdy, 0);
            return;
        end
        if (pid == 8'hE1) begin
            if (nb > 0) m_armed = (frame[1][7:1] == DEV);
            return;
        end
        if (pid != 8'hC3 && pid != 8'h4B) return;
        acc = m_armed && ((pid == 8'h4B) == m_tog);
        cut = nb;
        if (err_at >= 0) cut = err_at;
        if (rst_at >= 0) cut = rst_at;
        if (acc) begin
            for (int i = 0; i < cut && i < PB; i++)
                push((m_idx == 0 && i == 0) ? KEnQh : KEn, m_idx * PB + i);
        end
        if (rst_at >= 0) begin
            m_armed = 0; m_tog = 0; m_idx = 0;
            return;
        end
        if (err_at >= 0) begin
            push(KPerr, 0); push(KNack, 0); m_idx = 0;
            return;
        end
        if (!m_armed) return;
        if (!acc) begin
            push(KAck, 0);
            return;
        end
        if (nb != PB) begin
            push(KPerr, 0); push(KNack, 0); m_idx = 0;
            return;
        end
        if (m_idx == NP - 1) begin
            push(KNb, 0);
            m_idx = 0;
        end else begin
            m_idx++;
        end
        m_tog = !m_tog;
        push(KAck, 0);
    endfunction

    task automatic drive(input logic we, input logic [7:0] d, input logic e, input logic re);
        write_enable = we;
        rx_data      = d;
        eop          = e;
        rcv_error    = re;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic reset_mid();
        write_enable = 1'b0;
        eop          = 1'b0;
        rcv_error    = 1'b0;
        n_rst        = 1'b0;
        #1;
        chk("reset_mid_pulses", 32'({p_error, host_ready, quit_hash, new_block, transmit_ack,
                                     transmit_nack, i_data_en}), 32'd0);
        chk("reset_mid_sel", 32'(i_data_sel), 32'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        idle(2);
    endtask

    task automatic run_frame(input int err_at, input int rst_at);
        model_frame(err_at, rst_at);
        drive(1'b1, frame[0], 1'b0, 1'b0);
        for (int i = 1; i < frame.size(); i++) begin
            if (i - 1 == err_at) begin
                drive(1'b0, 8'h00, 1'b0, 1'b1);
                break;
            end
            if (i - 1 == rst_at) begin
                reset_mid();
                return;
            end
            if ($urandom_range(0, 3) == 0) idle(1);
            drive(1'b1, frame[i], 1'b0, 1'b0);
        end
        idle($urandom_range(0, 2));
        for (int i = $urandom_range(1, 3); i > 0; i--) drive(1'b0, 8'h00, 1'b1, 1'b0);
        idle($urandom_range(2, 3));
    endtask

    task automatic build(input logic [7:0] pid, input int n);
        frame.delete();
        frame.push_back(pid);
        for (int i = 0; i < n; i++) frame.push_back(8'($urandom));
    endtask

    task automatic token(input logic [7:0] pid, input logic [7:0] addr);
        frame.delete();
        frame.push_back(pid);
        frame.push_back(addr);
    endtask

    // Monitor: every cycle where the DUT shows any pulse, pop one expected event and compare.
    always @(negedge clk) begin
        ev_t obs;
        ev_t e;
        if (n_rst === 1'b1) begin
            obs      = '0;
            obs.perr = p_error;
            obs.hrdy = host_ready;
            obs.qh   = quit_hash;
            obs.nb   = new_block;
            obs.ack  = transmit_ack;
            obs.nack = transmit_nack;
            obs.en   = i_data_en;
            obs.sel  = i_data_en ? i_data_sel : '0;
            if (obs != '0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event got=%h expected=none", obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        bad++;
                        $display("FAIL event got=%h expected=%h", obs, e);
                    end
                end
            end
            if (i_data_en === 1'b1) begin
                total++;
                if (i_data !== rx_data) begin
                    bad++;
                    $display("FAIL i_data got=%h expected=%h", i_data, rx_data);
                end
            end
        end
    end

    initial begin
        logic [7:0] other[4];
        logic [7:0] x;
        int r;
        other[0] = 8'hD2; other[1] = 8'h5A; other[2] = 8'h1E; other[3] = 8'hA5;
        n_rst        = 1'b0;
        write_enable = 1'b0;
        rx_data      = 8'h00;
        eop          = 1'b0;
        rcv_error    = 1'b0;
        #12;
        chk("reset_pulses", 32'({p_error, host_ready, quit_hash, new_block, transmit_ack,
                                 transmit_nack, i_data_en}), 32'd0);
        chk("reset_sel", 32'(i_data_sel), 32'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        idle(2);

        // Directed: arm, full block, duplicates, errors, IN tokens, abort cases.
        token(8'hE1, 8'hC2); run_frame(-1, -1);
        build(8'hC3, PB);    run_frame(-1, -1);
        build(8'hC3, PB);    run_frame(-1, -1);
        build(8'h4B, PB);    run_frame(-1, -1);
        build(8'h4B, PB);    run_frame(-1, -1);
        build(8'h6A, 0);     run_frame(-1, -1);
        build(8'hC3, PB - 1); run_frame(-1, -1);
        build(8'hC3, PB + 1); run_frame(-1, -1);
        token(8'h69, 8'hC2); run_frame(-1, -1);
        token(8'h69, 8'h10); run_frame(-1, -1);
        build(8'hE1, 0);     run_frame(-1, -1);
        build(8'hC3, PB);    run_frame(20, -1);
        build(8'hC3, PB);    run_frame(-1, 5);
        build(8'hC3, PB);    run_frame(-1, -1);
        token(8'hE1, 8'hC3); run_frame(-1, -1);
        build(8'hC3, PB);    run_frame(-1, -1);

        for (int n = 0; n < 70; n++) begin
            r = $urandom_range(0, 10);
            x = ($urandom_range(0, 1) == 1) ? 8'h4B : 8'hC3;
            case (r)
                0: token(8'hE1, ($urandom_range(0, 3) != 0) ? {DEV, 1'(r)} : 8'($urandom));
                1: token(8'h69, ($urandom_range(0, 1) == 1) ? {DEV, 1'b1} : 8'($urandom));
                2, 3, 4: build(x, PB);
                5: build(x, ($urandom_range(0, 1) == 1) ? $urandom_range(0, PB - 1)
                                                        : $urandom_range(PB + 1, PB + 2));
                6: begin
                    x = 8'($urandom);
                    if (x[3:0] == ~x[7:4]) x[0] = ~x[0];
                    build(x, 0);
                end
                7: build(other[$urandom_range(0, 3)], $urandom_range(0, 3));
                8: build(x, PB);
                9: build(($urandom_range(0, 1) == 1) ? 8'h69 : 8'hE1, 0);
                default: token(8'hE1, {DEV, 1'b0});
            endcase
            if (r == 8) run_frame($urandom_range(0, PB - 1), -1);
            else if (r == 4 && $urandom_range(0, 4) == 0) run_frame(-1, $urandom_range(0, PB - 1));
            else run_frame(-1, -1);
        end

        idle(5);
        chk("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
